servo_readback: RTL and testbench

SPI read-back responder for the servo position path: the AVR issues read commands over the existing SPI byte link, and this block returns the position bytes currently driving the servo controllers. It sits beside the position-write decoder in the AVR interface. It consumes received bytes from the SPI slave and loads reply bytes for the next SPI transfer. It reads the latched output buffer, which is the same vector feeding the servo controllers.

---
 rtl/servo_pkg.sv | 30 +++
 rtl/servo_pos_mux.sv | 25 ++
 rtl/servo_readback.sv | 109 ++++++++++
 tb/tb_servo_readback.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo AVR interface: command opcodes, limits and
// read-back FSM states, used by both the write decoder and the read-back path.
package servo_pkg;

    localparam int MAX_SERVOS = 64;
    localparam logic [7:0] ERR_BYTE = 8'hFF;

    // Write-path opcodes live here too so both directions decode from one place.
    localparam logic [1:0] OP_WRITE     = 2'b00;
    localparam logic [1:0] OP_WRITE_ALT = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b01;
    localparam logic [1:0] OP_BURST     = 2'b11;

    typedef logic [5:0] index_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2
    } state_t;

    function automatic logic [1:0] cmd_op(input logic [7:0] cmd);
        return cmd[7:6];
    endfunction

    function automatic index_t cmd_idx(input logic [7:0] cmd);
        return cmd[5:0];
    endfunction

endpackage

// File: rtl/servo_pos_mux.sv
// Combinational byte selector: picks servo [idx] from a flat 8*NUM_SERVOS
// position vector and flags indices beyond the configured servo count.
module servo_pos_mux
    import servo_pkg::*;
#(
    parameter int NUM_SERVOS = 1
) (
    input  logic [8*NUM_SERVOS-1:0] pos_vec,
    input  logic [5:0]              idx,
    output logic [7:0]              pos,
    output logic                    out_of_range
);

    assign out_of_range = ({1'b0, idx} >= 7'(NUM_SERVOS));

    // NOTE: pos gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        pos = ERR_BYTE;
        for (int i = 0; i < NUM_SERVOS; i++) begin
            if (idx == 6'(i)) pos = pos_vec[8*i +: 8];
        end
    end

endmodule

// File: rtl/servo_readback.sv
// SPI read-back responder returning latched servo positions to the AVR.
// Optional macro SERVO_READBACK_SNAPSHOT_EN: replies come from a copy taken at command time.
module servo_readback
    import servo_pkg::*;
#(
    parameter int NUM_SERVOS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_ss,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic [8*NUM_SERVOS-1:0] output_buffer,
    input  logic                    err_clr,
    output logic [7:0]              tx_data,
    output logic                    tx_load,
    output logic                    busy,
    output logic                    err
);

    if (NUM_SERVOS < 1 || NUM_SERVOS > MAX_SERVOS) begin : g_bad_param
        $error("servo_readback: NUM_SERVOS out of range 1..64");
    end

    state_t                  state_q, state_d;
    index_t                  index_q, index_d;
    index_t                  sel_idx, burst_next;
    logic [7:0]              mux_pos, data_d;
    logic                    mux_oor, load_d, accept, err_set;
    logic [8*NUM_SERVOS-1:0] mux_vec;

    assign burst_next = (index_q == 6'(NUM_SERVOS - 1)) ? '0 : index_q + 6'd1;
    assign accept     = !spi_ss && rx_valid && (state_q != BURST) &&
                        ((cmd_op(rx_data) == OP_READ) || (cmd_op(rx_data) == OP_BURST));
    assign sel_idx    = (state_q == BURST) ? burst_next : cmd_idx(rx_data);

`ifdef SERVO_READBACK_SNAPSHOT_EN
    logic [8*NUM_SERVOS-1:0] shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         shadow_q <= '0;
        else if (accept) shadow_q <= output_buffer;
    end

    // The command cycle reads live data, matching what lands in the shadow.
    assign mux_vec = accept ? output_buffer : shadow_q;
`else
    assign mux_vec = output_buffer;
`endif

    servo_pos_mux #(.NUM_SERVOS(NUM_SERVOS)) u_pos_mux (
        .pos_vec      (mux_vec),
        .idx          (sel_idx),
        .pos          (mux_pos),
        .out_of_range (mux_oor)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        data_d  = tx_data;
        load_d  = 1'b0;
        err_set = 1'b0;
        if (spi_ss) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            if (state_q == BURST) begin
                index_d = burst_next;
                data_d  = mux_pos;
                load_d  = 1'b1;
            end else begin
                state_d = IDLE;
                if (accept) begin
                    load_d = 1'b1;
                    if (mux_oor) begin
                        data_d  = ERR_BYTE;
                        err_set = 1'b1;
                    end else begin
                        data_d  = mux_pos;
                        index_d = sel_idx;
                        state_d = (cmd_op(rx_data) == OP_READ) ? SINGLE : BURST;
                    end
                end
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            tx_data <= 8'h00;
            tx_load <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            tx_data <= data_d;
            tx_load <= load_d;
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_servo_readback.sv
// Self-checking bench for servo_readback: directed test-plan sequences plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_servo_readback;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst, spi_ss, rx_valid, err_clr;
    logic [7:0]     rx_data;
    logic [8*N-1:0] output_buffer;
    logic [7:0]     tx_data;
    logic           tx_load, busy, err;

    servo_readback #(.NUM_SERVOS(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_ss        (spi_ss),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .output_buffer (output_buffer),
        .err_clr       (err_clr),
        .tx_data       (tx_data),
        .tx_load       (tx_load),
        .busy          (busy),
        .err           (err)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an open transaction is either a single read
    // awaiting its closing byte or a burst walking the servo list.
    bit         m_open, m_burst;
    int         m_idx;
    logic [7:0] m_snap [N];
    logic [7:0] e_data;
    bit         e_load, e_err;

    function automatic logic [7:0] live_pos(input int i);
        return output_buffer[8*i +: 8];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_open <= 1'b0; m_burst <= 1'b0; m_idx <= 0;
            e_data <= 8'h00; e_load <= 1'b0; e_err <= 1'b0;
        end else begin : model_step
            automatic bit set_err = 1'b0;
            automatic int nxt;
            automatic int idx;
            e_load <= 1'b0;
            if (spi_ss) begin
                m_open <= 1'b0;
            end else if (rx_valid) begin
                if (m_open && m_burst) begin
                    nxt = (m_idx + 1) % N;
                    m_idx  <= nxt;
                    e_load <= 1'b1;
`ifdef SERVO_READBACK_SNAPSHOT_EN
                    e_data <= m_snap[nxt];
`else
                    e_data <= live_pos(nxt);
`endif
                end else begin
                    idx = int'(rx_data[5:0]);
                    m_open <= 1'b0;
                    if (rx_data[6]) begin
                        e_load <= 1'b1;
                        if (idx >= N) begin
                            e_data  <= 8'hFF;
                            set_err = 1'b1;
                        end else begin
                            e_data  <= live_pos(idx);
                            m_open  <= 1'b1;
                            m_burst <= rx_data[7];
                            m_idx   <= idx;
                            for (int i = 0; i < N; i++) m_snap[i] <= live_pos(i);
                        end
                    end
                end
            end
            if (set_err)      e_err <= 1'b1;
            else if (err_clr) e_err <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cyc_tx_load", 32'(tx_load), 32'(e_load));
            check("cyc_tx_data", 32'(tx_data), 32'(e_data));
            check("cyc_busy",    32'(busy),    32'(m_open));
            check("cyc_err",     32'(err),     32'(e_err));
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_reply(input string name, input logic [7:0] b);
        check({name, "_load"}, 32'(tx_load), 32'd1);
        check({name, "_data"}, 32'(tx_data), 32'(b));
    endtask

    initial begin
        rst = 1'b1; spi_ss = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; err_clr = 1'b0;
        output_buffer = {8'h40, 8'h30, 8'h20, 8'h10};
        #1;
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_load", 32'(tx_load), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_err",     32'(err),     32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0; spi_ss = 1'b0; cmp_en = 1'b1;

        send(8'h42);
        expect_reply("read1", 8'h30);
        check("read1_busy", 32'(busy), 32'd1);
        send(8'h00);
        check("close_load", 32'(tx_load), 32'd0);
        check("close_busy", 32'(busy), 32'd0);

        send(8'hC2); expect_reply("burst0", 8'h30);
        send(8'h00); expect_reply("burst1", 8'h40);
        send(8'h00); expect_reply("burst2_wrap", 8'h10);
        send(8'h00); expect_reply("burst3", 8'h20);

        @(negedge clk);
        spi_ss = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
        @(negedge clk);
        rx_valid = 1'b0;
        check("abort_load", 32'(tx_load), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        spi_ss = 1'b0;
        send(8'h40); expect_reply("after_abort", 8'h10);
        send(8'h00);

        send(8'h45);
        expect_reply("oor", 8'hFF);
        check("oor_err",  32'(err),  32'd1);
        check("oor_busy", 32'(busy), 32'd0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);
        @(negedge clk);
        rx_data = 8'h45; rx_valid = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; err_clr = 1'b0;
        check("err_set_wins", 32'(err), 32'd1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;

        send(8'hC0); expect_reply("snap0", 8'h10);
        output_buffer[15:8] = 8'h99;
        send(8'h00);
`ifdef SERVO_READBACK_SNAPSHOT_EN
        expect_reply("snap1", 8'h20);
`else
        expect_reply("snap1", 8'h99);
`endif
        @(negedge clk); spi_ss = 1'b1;
        @(negedge clk); spi_ss = 1'b0;
        output_buffer = {8'h40, 8'h30, 8'h20, 8'h10};

        begin : random_phase
            bit prev_valid = 1'b0;
            for (int k = 0; k < 600; k++) begin
                @(negedge clk);
                spi_ss   = ($urandom_range(0, 15) == 0);
                err_clr  = ($urandom_range(0, 7) == 0);
                rx_valid = !prev_valid && ($urandom_range(0, 1) == 1);
                rx_data  = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 6))};
                if ($urandom_range(0, 3) == 0)
                    output_buffer[8*$urandom_range(0, N-1) +: 8] = 8'($urandom);
                prev_valid = rx_valid;
            end
            @(negedge clk);
            rx_valid = 1'b0; spi_ss = 1'b0; err_clr = 1'b0;
        end

        @(negedge clk); spi_ss = 1'b1;
        @(negedge clk); spi_ss = 1'b0;
        output_buffer = {8'h40, 8'h30, 8'h20, 8'h10};
        send(8'hC1); expect_reply("pre_rst0", 8'h20);
        send(8'h00); expect_reply("pre_rst1", 8'h30);
        #5 rst = 1'b1;
        #1;
        check("arst_tx_data", 32'(tx_data), 32'h00);
        check("arst_tx_load", 32'(tx_load), 32'd0);
        check("arst_busy",    32'(busy),    32'd0);
        check("arst_err",     32'(err),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h00);
        check("post_rst_load0", 32'(tx_load), 32'd0);
        send(8'h00);
        check("post_rst_load1", 32'(tx_load), 32'd0);
        check("post_rst_data",  32'(tx_data), 32'h00);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
